multicycle_core: RTL and testbench

- Parametrised multi-cycle processor core: fetch, execute, optional memory phase, with a 32-bit fixed instruction word.
- Talks to a single-port word-addressed memory through a req/ack handshake, so memories with any wait-state count are supported.
- Adds conditional branching, logic ops, halt, illegal-opcode detection and retire/debug outputs.
- Sits at the top of the processor subsystem, next to the RAM model.

---
 rtl/core_pkg.sv | 63 ++++++
 rtl/multicycle_core_if.sv | 23 ++
 rtl/core_alu.sv | 27 ++
 rtl/multicycle_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types for the multi-cycle core: opcodes, FSM states,
// ALU operations and instruction field positions.
package core_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_MUL   = 5'd3,
    OP_COPY  = 5'd7,
    OP_JMP   = 5'd8,
    OP_LOAD  = 5'd9,
    OP_STORE = 5'd10,
    OP_SET   = 5'd11,
    OP_AND   = 5'd12,
    OP_OR    = 5'd13,
    OP_XOR   = 5'd14,
    OP_JZ    = 5'd15,
    OP_HALT  = 5'd31
  } opcode_t;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int R1_HI  = 26;
  localparam int R1_LO  = 24;
  localparam int R2_HI  = 23;
  localparam int R2_LO  = 21;
  localparam int R3_HI  = 20;
  localparam int R3_LO  = 18;
  localparam int IMM_HI = 20;
  localparam int IMM_LO = 5;

  function automatic alu_op_t alu_sel(input opcode_t op);
    alu_op_t sel;
    sel = ALU_ADD;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_MUL:  sel = ALU_MUL;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_XOR:  sel = ALU_XOR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Single-port word memory bus with a req/ack handshake.
// The core is the master; the memory answers with ack.
interface multicycle_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/core_alu.sv
// Combinational ALU of the multi-cycle core.
// Results wrap modulo 2^DATA_W.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_MUL: result = a * b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: BOOT, FETCH, EXEC, optional MEM, HALT.
// Register file, pc and FSM live here; the ALU is a sub-block.
module multicycle_core
  import core_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  multicycle_core_if.master mem,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retired,
  output logic              o_halted,
  output logic              o_illegal
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_a;
  logic [ADDR_W-1:0] br_tgt;
  logic [31:0]       ir;
  logic [DATA_W-1:0] rf [8];

  opcode_t           opc;
  alu_op_t           alu_op;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [2:0]        rc;
  logic [15:0]       imm;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] imm_d;
  logic              is_alu;
  logic              is_mov;
  logic              is_br;
  logic              is_mem;
  logic              is_halt;
  logic              done;
  logic              unused_ir;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ret_q;
  logic              halt_q;
  logic              ill_q;

  logic              req_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              ret_nxt;
  logic              halt_nxt;
  logic              ill_nxt;
  logic              ir_we;
  logic              rf_we;
  logic [2:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  assign opc       = opcode_t'(ir[OPC_HI:OPC_LO]);
  assign ra        = ir[R1_HI:R1_LO];
  assign rb        = ir[R2_HI:R2_LO];
  assign rc        = ir[R3_HI:R3_LO];
  assign imm       = ir[IMM_HI:IMM_LO];
  assign imm_d     = DATA_W'(imm);
  assign imm_a     = imm[ADDR_W-1:0];
  assign a         = rf[ra];
  assign b         = rf[rb];
  assign alu_op    = alu_sel(opc);
  assign pc_inc    = pc + ADDR_W'(1);
  assign unused_ir = ^ir[IMM_LO-1:0];

  assign is_alu  = opc inside {OP_ADD, OP_SUB, OP_MUL,
                               OP_AND, OP_OR, OP_XOR};
  assign is_mov  = opc inside {OP_COPY, OP_SET};
  assign is_br   = opc inside {OP_JMP, OP_JZ};
  assign is_mem  = opc inside {OP_LOAD, OP_STORE};
  assign is_halt = (opc == OP_HALT);

  assign br_tgt = (opc == OP_JMP || a == '0) ? imm_a : pc_inc;

  // An ack with no request outstanding is ignored.
  assign done = req_q & mem.ack;

  core_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (a),
    .b      (b),
    .op     (alu_op),
    .result (alu_y)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_BOOT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (done) state_nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mem:                state_nxt = S_MEM;
          is_alu, is_mov, is_br: state_nxt = S_FETCH;
          default:               state_nxt = S_HALT;
        endcase
      end
      S_MEM:   if (done) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    req_nxt   = req_q;
    we_nxt    = we_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    ret_nxt   = 1'b0;
    halt_nxt  = halt_q;
    ill_nxt   = ill_q;
    pc_nxt    = pc;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = ra;
    rf_wd     = alu_y;
    unique case (state)
      S_BOOT: begin
        req_nxt  = 1'b1;
        we_nxt   = 1'b0;
        addr_nxt = pc;
      end
      S_FETCH: begin
        if (done) begin
          ir_we   = 1'b1;
          req_nxt = 1'b0;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu, is_mov: begin
            rf_we    = 1'b1;
            rf_wa    = is_alu ? rc : ra;
            rf_wd    = is_alu ? alu_y
                     : (opc == OP_SET) ? imm_d : b;
            pc_nxt   = pc_inc;
            ret_nxt  = 1'b1;
            req_nxt  = 1'b1;
            we_nxt   = 1'b0;
            addr_nxt = pc_inc;
          end
          is_br: begin
            pc_nxt   = br_tgt;
            ret_nxt  = 1'b1;
            req_nxt  = 1'b1;
            we_nxt   = 1'b0;
            addr_nxt = br_tgt;
          end
          is_mem: begin
            req_nxt   = 1'b1;
            we_nxt    = (opc == OP_STORE);
            addr_nxt  = imm_a;
            wdata_nxt = a;
          end
          is_halt: begin
            halt_nxt = 1'b1;
            ret_nxt  = 1'b1;
          end
          default: begin
            halt_nxt = 1'b1;
            ill_nxt  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (done) begin
          rf_we    = ~we_q;
          rf_wd    = mem.rdata;
          pc_nxt   = pc_inc;
          ret_nxt  = 1'b1;
          req_nxt  = 1'b1;
          we_nxt   = 1'b0;
          addr_nxt = pc_inc;
        end
      end
      S_HALT: begin
        req_nxt = 1'b0;
      end
      default: begin
        req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ret_q   <= 1'b0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      pc      <= pc_nxt;
      req_q   <= req_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ret_q   <= ret_nxt;
      halt_q  <= halt_nxt;
      ill_q   <= ill_nxt;
      if (ir_we) ir <= 32'(mem.rdata);
      if (rf_we) rf[rf_wa] <= rf_wd;
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign o_pc      = pc;
  assign o_retired = ret_q;
  assign o_halted  = halt_q;
  assign o_illegal = ill_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: wait-state memory, directed
// programs and random programs against an ISA-level model.
module tb_multicycle_core;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MW = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc;
  logic          retired;
  logic          halted;
  logic          illegal;

  always #5 clk = ~clk;

  multicycle_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  multicycle_core #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RESET_PC (16'd0)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .mem       (bus),
    .o_pc      (pc),
    .o_retired (retired),
    .o_halted  (halted),
    .o_illegal (illegal)
  );

  logic [31:0]   ram [MW];
  int            waits = 0;
  bit            rnd_w = 1'b0;
  int            cur_w = 0;
  int            cnt = 0;
  bit            pending = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata;
  int            n_wr = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int            n_chk = 0;
  int            n_pass = 0;
  int            last_cyc;
  int            last_rets;

  logic [31:0]   m_mem [MW];
  logic [31:0]   m_r [8];
  logic [15:0]   m_pc;
  int            m_ret;
  int            m_cyc;
  bit            m_ill;

  int alu_ops [6] = '{0, 1, 3, 12, 13, 14};
  int bad_ops [8] = '{2, 4, 5, 6, 16, 20, 25, 30};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h",
                  tag, got, exp);
  endtask

  // Memory: acks after cur_w wait cycles, checks hold stability.
  initial begin
    bus.ack   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (pending && !rst) begin
        chk("hold_req", 64'(bus.req), 64'(1));
        chk("hold_addr", 64'(bus.addr), 64'(h_addr));
        chk("hold_we", 64'(bus.we), 64'(h_we));
        chk("hold_wdata", 64'(bus.wdata), 64'(h_wdata));
      end else begin
        cnt   = 0;
        cur_w = rnd_w ? int'($urandom_range(0, 3)) : waits;
      end
      bus.ack = 1'b0;
      pending = 1'b0;
      if (bus.req && !rst) begin
        h_addr  = bus.addr;
        h_we    = bus.we;
        h_wdata = bus.wdata;
        if (cnt >= cur_w) begin
          bus.ack   = 1'b1;
          bus.rdata = ram[bus.addr[9:0]];
          if (bus.we) begin
            ram[bus.addr[9:0]] = bus.wdata;
            wr_addr = bus.addr;
            wr_data = bus.wdata;
            n_wr++;
          end
        end else begin
          cnt++;
          pending = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input int op, input int a,
                                        input int b, input int c);
    return {5'(op), 3'(a), 3'(b), 3'(c), 18'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int a,
                                        input int im);
    return {5'(op), 3'(a), 3'd0, 16'(im), 5'd0};
  endfunction

  function automatic int rr();
    return int'($urandom_range(0, 7));
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < MW; i++) ram[i] = '0;
  endtask

  task automatic model_run(input int w);
    logic [31:0] ins;
    logic [4:0]  op;
    logic [2:0]  ra, rb, rc;
    logic [15:0] im;
    bit          stop;
    stop  = 1'b0;
    m_pc  = '0;
    m_ret = 0;
    m_ill = 1'b0;
    m_cyc = 1;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    for (int s = 0; s < 3000 && !stop; s++) begin
      ins = m_mem[m_pc[9:0]];
      op  = ins[31:27];
      ra  = ins[26:24];
      rb  = ins[23:21];
      rc  = ins[20:18];
      im  = ins[20:5];
      m_cyc += w + 2;
      case (op)
        5'd0:  begin m_r[rc] = m_r[ra] + m_r[rb]; m_pc++; end
        5'd1:  begin m_r[rc] = m_r[ra] - m_r[rb]; m_pc++; end
        5'd3:  begin m_r[rc] = m_r[ra] * m_r[rb]; m_pc++; end
        5'd12: begin m_r[rc] = m_r[ra] & m_r[rb]; m_pc++; end
        5'd13: begin m_r[rc] = m_r[ra] | m_r[rb]; m_pc++; end
        5'd14: begin m_r[rc] = m_r[ra] ^ m_r[rb]; m_pc++; end
        5'd7:  begin m_r[ra] = m_r[rb]; m_pc++; end
        5'd11: begin m_r[ra] = 32'(im); m_pc++; end
        5'd9: begin
          m_r[ra] = m_mem[im[9:0]];
          m_pc++;
          m_cyc += w + 1;
        end
        5'd10: begin
          m_mem[im[9:0]] = m_r[ra];
          m_pc++;
          m_cyc += w + 1;
        end
        5'd8:  m_pc = im;
        5'd15: m_pc = (m_r[ra] == 0) ? im : m_pc + 16'd1;
        5'd31: stop = 1'b1;
        default: begin stop = 1'b1; m_ill = 1'b1; end
      endcase
      if (!m_ill) m_ret++;
    end
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (check_vals) begin
      chk("rst_req", 64'(bus.req), 64'(0));
      chk("rst_we", 64'(bus.we), 64'(0));
      chk("rst_addr", 64'(bus.addr), 64'(0));
      chk("rst_wdata", 64'(bus.wdata), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      chk("rst_halted", 64'(halted), 64'(0));
      chk("rst_illegal", 64'(illegal), 64'(0));
      chk("rst_pc", 64'(pc), 64'(0));
    end
    rst = 1'b0;
  endtask

  task automatic run(input string tag, input int w, input bit rnd);
    int cyc;
    int diffs;
    bit req_after;
    waits = w;
    rnd_w = rnd;
    for (int i = 0; i < MW; i++) m_mem[i] = ram[i];
    model_run(w);
    n_wr = 0;
    do_reset(1'b0);
    cyc       = 0;
    last_cyc  = -1;
    last_rets = 0;
    while (last_cyc < 0 && cyc < 4000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (retired) last_rets++;
      if (halted) last_cyc = cyc;
    end
    chk({tag, "_timeout"}, 64'(last_cyc < 0), 64'(0));
    req_after = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req) req_after = 1'b1;
      if (retired) last_rets++;
    end
    chk({tag, "_req_after_halt"}, 64'(req_after), 64'(0));
    chk({tag, "_illegal"}, 64'(illegal), 64'(m_ill));
    chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
    chk({tag, "_retired"}, 64'(last_rets), 64'(m_ret));
    if (!rnd) chk({tag, "_cycles"}, 64'(last_cyc), 64'(m_cyc));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_r%0d", tag, i), 64'(dut.rf[i]), 64'(m_r[i]));
    diffs = 0;
    for (int i = 0; i < MW; i++)
      if (ram[i] !== m_mem[i]) diffs++;
    chk({tag, "_mem_diffs"}, 64'(diffs), 64'(0));
  endtask

  task automatic load_a();
    clear_ram();
    ram[0] = enc_i(11, 1, 5);
    ram[1] = enc_i(11, 2, 7);
    ram[2] = enc_r(0, 1, 2, 3);
    ram[3] = enc_i(31, 0, 0);
  endtask

  task automatic gen_prog();
    int len, k, t;
    clear_ram();
    len = int'($urandom_range(8, 20));
    for (int i = 0; i < len - 1; i++) begin
      k = int'($urandom_range(0, 15));
      t = int'($urandom_range(i + 1, len - 1));
      case (k)
        0, 1, 2, 3, 4, 5:
          ram[i] = enc_r(alu_ops[$urandom_range(0, 5)], rr(), rr(), rr());
        6:  ram[i] = enc_r(7, rr(), rr(), 0);
        7, 8: ram[i] = enc_i(11, rr(), int'($urandom_range(0, 65535)));
        9:  ram[i] = enc_i(10, rr(), 512 + int'($urandom_range(0, 15)));
        10: ram[i] = enc_i(9, rr(), 512 + int'($urandom_range(0, 15)));
        11: ram[i] = enc_i(8, 0, t);
        12, 13: ram[i] = enc_i(15, rr(), t);
        14: ram[i] = ($urandom_range(0, 3) == 0)
                   ? enc_r(bad_ops[$urandom_range(0, 7)], 0, 0, 0)
                   : enc_i(11, rr(), int'($urandom_range(0, 3)));
        default: ram[i] = enc_r(3, rr(), rr(), rr());
      endcase
    end
    ram[len - 1] = enc_i(31, 0, 0);
    for (int i = 512; i < 528; i++) ram[i] = $urandom;
  endtask

  initial begin
    bit found;
    #1 rst = 1'b1;
    clear_ram();
    do_reset(1'b1);

    load_a();
    run("a_w0", 0, 1'b0);
    chk("a_w0_r3_const", 64'(dut.rf[3]), 64'(12));
    chk("a_w0_halt_cycle", 64'(last_cyc), 64'(9));
    chk("a_w0_retire_cnt", 64'(last_rets), 64'(4));

    load_a();
    run("a_w3", 3, 1'b0);
    chk("a_w3_r3_const", 64'(dut.rf[3]), 64'(12));
    chk("a_w3_halt_cycle", 64'(last_cyc), 64'(21));

    clear_ram();
    ram[0] = enc_i(11, 1, 3);
    ram[1] = enc_i(11, 2, 1);
    ram[2] = enc_r(1, 1, 2, 1);
    ram[3] = enc_i(15, 1, 5);
    ram[4] = enc_i(8, 0, 2);
    ram[5] = enc_i(31, 0, 0);
    run("jz_w0", 0, 1'b0);
    chk("jz_pc_const", 64'(pc), 64'(5));
    chk("jz_r1_const", 64'(dut.rf[1]), 64'(0));
    chk("jz_retire_cnt", 64'(last_rets), 64'(11));
    run("jz_w2", 2, 1'b0);

    clear_ram();
    ram[0] = enc_i(11, 1, 16'hABCD);
    ram[1] = enc_i(10, 1, 40);
    ram[2] = enc_i(9, 4, 40);
    ram[3] = enc_i(31, 0, 0);
    run("ls_w1", 1, 1'b0);
    chk("ls_write_count", 64'(n_wr), 64'(1));
    chk("ls_write_addr", 64'(wr_addr), 64'(40));
    chk("ls_write_data", 64'(wr_data), 64'(32'hABCD));
    chk("ls_r4_const", 64'(dut.rf[4]), 64'(32'hABCD));

    clear_ram();
    ram[0] = enc_i(11, 1, 1);
    ram[1] = enc_i(11, 2, 2);
    ram[2] = enc_r(20, 0, 0, 0);
    ram[3] = enc_i(31, 0, 0);
    run("ill_w0", 0, 1'b0);
    chk("ill_flag_const", 64'(illegal), 64'(1));
    chk("ill_halted_const", 64'(halted), 64'(1));
    chk("ill_pc_const", 64'(pc), 64'(2));

    for (int n = 0; n < 20; n++) begin
      gen_prog();
      run($sformatf("rnd%0d", n), 0, 1'b1);
    end

    clear_ram();
    ram[0]  = enc_i(11, 1, 16'h1234);
    ram[1]  = enc_i(9, 2, 40);
    ram[2]  = enc_i(31, 0, 0);
    ram[40] = 32'h5555;
    waits = 5;
    rnd_w = 1'b0;
    do_reset(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.req && bus.addr == 16'd40) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_found_data_req", 64'(found), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_req_drop", 64'(bus.req), 64'(0));
    chk("mid_addr_zero", 64'(bus.addr), 64'(0));
    chk("mid_r1_zero", 64'(dut.rf[1]), 64'(0));
    chk("mid_pc_reset", 64'(pc), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_boot_no_req", 64'(bus.req), 64'(0));
    @(negedge clk);
    chk("mid_fetch_req", 64'(bus.req), 64'(1));
    chk("mid_fetch_addr", 64'(bus.addr), 64'(0));
    chk("mid_fetch_we", 64'(bus.we), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
